// File: rtl/mioc_gate_array_pipe_if.sv
// Stream bundle for the mioc gate array pipe.
// Input beats flow master->slave and results flow slave->master.
interface mioc_gate_array_pipe_if #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_bus;
    logic              out_valid;
    logic              out_ready;
    logic [NUM_CH-1:0] z;
    logic [NUM_CH-1:0] z_chg;

    modport master (
        output in_valid, in_bus, out_ready,
        input  in_ready, out_valid, z, z_chg
    );

    modport slave (
        input  in_valid, in_bus, out_ready,
        output in_ready, out_valid, z, z_chg
    );
endinterface

// File: rtl/mioc_gate_array_pipe.sv
// Two-stage pipelined array of AND-group gates.
// Each channel applies its own AND/OR/NAND/NOR mode.
module mioc_gate_array_pipe #(
    parameter int NUM_CH  = 4,
    parameter int NUM_GRP = 2,
    parameter int GRP_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [2*NUM_CH-1:0]   cfg_mode,
    mioc_gate_array_pipe_if.slave bus
);
    localparam int NG = NUM_CH * NUM_GRP;

    logic [2*NUM_CH-1:0] mode_q;
    logic [NG-1:0]       grp_d;
    logic [NG-1:0]       s1_grp;
    logic [2*NUM_CH-1:0] s1_mode;
    logic                s1_v;
    logic                s2_v;
    logic [NUM_CH-1:0]   z_q;
    logic [NUM_CH-1:0]   chg_q;
    logic [NUM_CH-1:0]   z_prev;
    logic [NUM_CH-1:0]   z_new;
    logic [NUM_CH-1:0]   z_ref;
    logic                s2_adv;
    logic                acc;
    logic                out_xfer;

    assign s2_adv       = !s2_v || bus.out_ready;
    assign bus.in_ready = !s1_v || s2_adv;
    assign acc          = bus.in_valid && bus.in_ready;
    assign out_xfer     = s2_v && bus.out_ready;

    assign bus.out_valid = s2_v;
    assign bus.z         = z_q;
    assign bus.z_chg     = chg_q;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            assign grp_d[gi] = &bus.in_bus[gi*GRP_W +: GRP_W];
        end
        // mode bit 1 inverts, mode bit 0 picks OR over AND
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic all_g;
            logic any_g;
            assign all_g = &s1_grp[gi*NUM_GRP +: NUM_GRP];
            assign any_g = |s1_grp[gi*NUM_GRP +: NUM_GRP];
            assign z_new[gi] = s1_mode[2*gi+1]
                             ^ (s1_mode[2*gi] ? any_g : all_g);
        end
    endgenerate

    // The beat leaving S2 this cycle is the previous delivered one
    assign z_ref = out_xfer ? z_q : z_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= '0;
        end else if (cfg_we) begin
            mode_q <= cfg_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_grp  <= '0;
            s1_mode <= '0;
        end else if (bus.in_ready) begin
            s1_v <= bus.in_valid;
            if (acc) begin
                s1_grp  <= grp_d;
                s1_mode <= mode_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v  <= 1'b0;
            z_q   <= '0;
            chg_q <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                z_q   <= z_new;
                chg_q <= z_new ^ z_ref;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_prev <= '0;
        end else if (out_xfer) begin
            z_prev <= z_q;
        end
    end
endmodule

// File: tb/tb_mioc_gate_array_pipe.sv
// Randomized scoreboard bench for mioc_gate_array_pipe.
// Expected results are queued at acceptance and popped by a monitor.
module tb_mioc_gate_array_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_mode = '0;

    int checks = 0;
    int failures = 0;

    logic [7:0] sb[$];
    logic [7:0] shadow_mode = '0;
    logic [3:0] prev_z = '0;

    logic       held_v = 1'b0;
    logic [3:0] held_z;
    logic [3:0] held_c;

    mioc_gate_array_pipe_if #(.NUM_CH(4), .IN_W(16)) bus ();

    mioc_gate_array_pipe #(
        .NUM_CH(4), .NUM_GRP(2), .GRP_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_we(cfg_we),
        .cfg_mode(cfg_mode),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_z(input logic [15:0] b,
                                         input logic [7:0] m);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            int n_true;
            int md;
            n_true = 0;
            for (int g = 0; g < 2; g++)
                if (((b >> ((k*2+g)*2)) & 16'd3) == 16'd3) n_true++;
            md = int'((m >> (2*k)) & 8'd3);
            case (md)
                0: r[k] = (n_true == 2);
                1: r[k] = (n_true > 0);
                2: r[k] = !(n_true == 2);
                default: r[k] = !(n_true > 0);
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle; record acceptance in the scoreboard.
    task automatic cyc(input logic v, input logic [15:0] b,
                       input logic ordy, input logic we,
                       input logic [7:0] m);
        logic [3:0] ze;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_bus    = b;
        bus.out_ready = ordy;
        cfg_we        = we;
        cfg_mode      = m;
        #1;
        chk("in_ready", {7'd0, bus.in_ready},
            {7'd0, !(sb.size() >= 2 && !ordy)});
        if (v && bus.in_ready) begin
            ze = ref_z(b, shadow_mode);
            sb.push_back({ze ^ prev_z, ze});
            prev_z = ze;
        end
        if (we) shadow_mode = m;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bus = 16'hFFFF;
        bus.out_ready = 1'b1;
        cfg_we = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        prev_z = '0;
        shadow_mode = '0;
        chk("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("rst_z", {4'd0, bus.z}, 8'd0);
        chk("rst_z_chg", {4'd0, bus.z_chg}, 8'd0);
        chk("rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        #2;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", {7'd0, bus.out_valid}, 8'd1);
                chk("hold_z", {bus.z_chg, bus.z}, {held_c, held_z});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 8'd1, 8'd0);
                end else begin
                    e = sb.pop_front();
                    chk("z", {4'd0, bus.z}, {4'd0, e[3:0]});
                    chk("z_chg", {4'd0, bus.z_chg}, {4'd0, e[7:4]});
                end
            end
            held_v = bus.out_valid && !bus.out_ready;
            held_z = bus.z;
            held_c = bus.z_chg;
        end
    end

    initial begin
        logic [15:0] b;
        logic [7:0]  m;
        bus.in_valid = 1'b0;
        bus.in_bus = '0;
        bus.out_ready = 1'b1;

        do_reset();

        // all ones in mode 0, twice
        cyc(1, 16'hFFFF, 1, 0, 8'h00);
        cyc(1, 16'hFFFF, 1, 0, 8'h00);
        cyc(0, 16'h0000, 1, 0, 8'h00);
        cyc(0, 16'h0000, 1, 0, 8'h00);

        // legacy sweep of channel 0
        for (int i = 0; i < 16; i++) begin
            b = 16'($urandom) & 16'hFFF0;
            cyc(1, b | 16'(i), 1, 0, 8'h00);
        end

        // mixed modes, grp0 true grp1 false everywhere
        cyc(0, 16'h0000, 1, 1, 8'b11_10_01_00);
        cyc(1, 16'h3333, 1, 0, 8'b11_10_01_00);

        // streaming with out_ready toggling
        for (int i = 0; i < 10; i++)
            cyc(1, 16'($urandom), (i % 2) == 0, 0, 8'h00);
        for (int i = 0; i < 6; i++)
            cyc(0, 16'h0000, 1, 0, 8'h00);

        // mode write in the same cycle as beat A
        cyc(1, 16'h3333, 1, 1, 8'hFF);
        cyc(1, 16'h3333, 1, 0, 8'hFF);
        cyc(1, 16'hFFFF, 1, 1, 8'h00);
        cyc(1, 16'hFFFF, 1, 0, 8'h00);

        // reset with beats in flight
        cyc(1, 16'hFFFF, 0, 0, 8'h00);
        cyc(1, 16'hFFFF, 0, 0, 8'h00);
        do_reset();
        cyc(1, 16'hFFFF, 1, 0, 8'h00);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            m = 8'($urandom);
            cyc(1'($urandom), 16'($urandom), 1'($urandom),
                ($urandom_range(0, 9) == 0), m);
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++)
            cyc(0, 16'h0000, 1, 0, 8'h00);
        chk("drain_empty", 8'(sb.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
